divide_unit: RTL and testbench
==============================

DIVIDE_UNIT -- requirements
Module: divide_unit

Interface
REQ-001 The module SHALL have parameter N, default 32, giving the operand/result width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: request a division, sampled only in IDLE.
REQ-005 The module SHALL have port a, input, N bits: unsigned dividend, captured on the accepted start edge.
REQ-006 The module SHALL have port b, input, N bits: unsigned divisor, captured on the accepted start edge.
REQ-007 The module SHALL have port q, output, N bits: registered quotient.
REQ-008 The module SHALL have port r, output, N bits: registered remainder.
REQ-009 The module SHALL have port busy, output, 1 bit: high while in RUN.
REQ-010 The module SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 The module SHALL have port zero, output, 1 bit: registered flag, quotient equals 0.
REQ-012 The module SHALL have port overflow, output, 1 bit: registered flag, divisor was 0.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE with start=1 at edge t0, the FSM SHALL latch a and b, clear the partial remainder, load iteration count N and enter RUN.
REQ-015 In RUN, each edge SHALL perform one restoring-division step, MSB first: shift {rem, dividend} left 1; if rem >= b then subtract b and set the quotient bit to 1, else set it to 0.
REQ-016 The partial remainder SHALL be N+1 bits wide, so the compare and subtract cannot overflow.
REQ-017 At edge t0+N the last step SHALL complete, q/r/zero/overflow SHALL update, and the FSM SHALL enter DONE.
REQ-018 done SHALL be 1 for exactly the one cycle spent in DONE; the FSM SHALL return to IDLE on the next edge.
REQ-019 The start-to-done latency SHALL be fixed at N cycles, independent of the operand values (macro off).
REQ-020 Divisor 0 SHALL yield q = all ones, r = a and overflow=1, as the natural restoring result.
REQ-021 zero SHALL equal (q == 0), evaluated on the final result.
REQ-022 start SHALL be ignored in RUN and in DONE; a and b changing during RUN SHALL have no effect.
REQ-023 q, r, zero and overflow SHALL hold their values from the last completion until the next completion or reset.
REQ-024 busy SHALL equal (state == RUN); busy and done SHALL never be high together.

Reset
REQ-025 rst=1 at any edge SHALL force IDLE and set q=0, r=0, busy=0, done=0, zero=0 and overflow=0.
REQ-026 Reset SHALL take priority over start and over any RUN step.
REQ-027 A division in progress when rst is asserted SHALL be abandoned with no done pulse; rst and start in the same cycle SHALL start nothing.

Configuration
REQ-028 The macro DIVIDE_UNIT_EARLY_EXIT_EN SHALL control an early-exit feature.
REQ-029 With DIVIDE_UNIT_EARLY_EXIT_EN defined, an accepted start with b==0 or a<b SHALL go directly IDLE->DONE at t0.
REQ-030 In that early-exit case, results SHALL be identical to REQ-020/REQ-021 (for a<b: q=0, r=a, zero=1), with done in the cycle after t0 and busy never asserted.
REQ-031 With DIVIDE_UNIT_EARLY_EXIT_EN undefined, every division SHALL take the full N-cycle RUN path.

Verification
REQ-032 a=100, b=7, start pulse -> done after N cycles; q=14, r=2, zero=0, overflow=0.
REQ-033 a=5, b=0 -> q=0xFFFFFFFF, r=5, overflow=1; done at N cycles (macro off) or 1 cycle (macro on).
REQ-034 a=3, b=10 -> q=0, r=3, zero=1; latency N (macro off) or 1 (macro on).
REQ-035 a=0xFFFFFFFF, b=1 -> q=0xFFFFFFFF, r=0; then a=0xFFFFFFFF, b=0xFFFFFFFF -> q=1, r=0.
REQ-036 Start 100/7, pulse start again with 9/3 mid-RUN -> second start ignored; q=14, r=2, exactly one done.
REQ-037 Start 100/7, assert rst at cycle 10 -> all outputs 0, no done pulse; a subsequent 9/3 -> q=3, r=0.

Source files
------------

// File: rtl/divide_unit.sv
// Unsigned restoring divider, one quotient bit per cycle; DIVIDE_UNIT_EARLY_EXIT_EN skips RUN for b==0 or a<b.
// Latency N cycles start-to-done (1 with early exit); start is only honoured in IDLE, never stalls.
module divide_unit #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] q,
   output logic [N-1:0] r,
   output logic         busy,
   output logic         done,
   output logic         zero,
   output logic         overflow
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [N:0]    rem_q, rem_d;
   logic [N-1:0]  dvd_q, dvd_d;
   logic [N-1:0]  dsr_q, dsr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  q_q, q_d;
   logic [N-1:0]  r_q, r_d;
   logic          zero_q, zero_d;
   logic          ovf_q, ovf_d;

   logic [N:0]    shifted;
   logic [N:0]    diff;
   logic          ge;
   logic [N:0]    step_rem;
   logic [N-1:0]  step_dvd;

   // One restoring step: the dividend register doubles as the quotient shift register.
   always_comb begin
      shifted  = {rem_q[N-1:0], dvd_q[N-1]};
      diff     = shifted - {1'b0, dsr_q};
      ge       = (shifted >= {1'b0, dsr_q});
      step_rem = ge ? diff : shifted;
      step_dvd = {dvd_q[N-2:0], ge};
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      r_d     = r_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               dvd_d = a;
               dsr_d = b;
               rem_d = '0;
               cnt_d = CW'(N);
`ifdef DIVIDE_UNIT_EARLY_EXIT_EN
               if (b == '0 || a < b) begin
                  state_d = DONE;
                  q_d     = (b == '0) ? {N{1'b1}} : {N{1'b0}};
                  r_d     = a;
                  zero_d  = (b != '0);
                  ovf_d   = (b == '0);
               end else begin
                  state_d = RUN;
               end
`else
               state_d = RUN;
`endif
            end
         end
         RUN: begin
            rem_d = step_rem;
            dvd_d = step_dvd;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
               q_d     = step_dvd;
               r_d     = step_rem[N-1:0];
               zero_d  = (step_dvd == '0);
               ovf_d   = (dsr_q == '0);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         // A partial remainder is always below the divisor, so its top bit stays clear.
         if (state_q == RUN) begin
            assert (rem_q[N] == 1'b0);
         end
         state_q <= state_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
      end
   end

   assign q        = q_q;
   assign r        = r_q;
   assign zero     = zero_q;
   assign overflow = ovf_q;
   assign busy     = (state_q == RUN);
   assign done     = (state_q == DONE);

endmodule

// File: tb/tb_divide_unit.sv
// Directed-vector bench for divide_unit; expectations follow DIVIDE_UNIT_EARLY_EXIT_EN when defined.
module tb_divide_unit;

   localparam int N = 32;
`ifdef DIVIDE_UNIT_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [N-1:0] q;
   logic [N-1:0] r;
   logic         busy;
   logic         done;
   logic         zero;
   logic         overflow;

   int tests_run  = 0;
   int tests_fail = 0;
   int done_cnt   = 0;
   int overlap    = 0;

   divide_unit #(.N(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
      .q        (q),
      .r        (r),
      .busy     (busy),
      .done     (done),
      .zero     (zero),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (done && busy) overlap++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_fail++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // short_path marks operands that qualify for the early exit (b==0 or a<b).
   task automatic run_div(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tbv,
                          input logic [N-1:0] exp_q, input logic [N-1:0] exp_r,
                          input logic exp_z, input logic exp_o, input logic short_path);
      int   cyc;
      int   exp_lat;
      logic busy_first;
      exp_lat = (EARLY && short_path) ? 0 : N;
      @(negedge clk);
      a     = ta;
      b     = tbv;
      start = 1'b1;
      @(posedge clk);
      #1;
      start      = 1'b0;
      busy_first = busy;
      cyc        = 0;
      while (!done && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk({tag, "_busy"}, 64'(busy_first), 64'(exp_lat != 0));
      chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
      chk({tag, "_q"}, 64'(q), 64'(exp_q));
      chk({tag, "_r"}, 64'(r), 64'(exp_r));
      chk({tag, "_zero"}, 64'(zero), 64'(exp_z));
      chk({tag, "_ovf"}, 64'(overflow), 64'(exp_o));
      @(posedge clk);
      #1;
      chk({tag, "_done_pulse"}, 64'(done), 64'(0));
   endtask

   initial begin
      int d0;
      int cyc;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_q", 64'(q), 64'(0));
      chk("rst_r", 64'(r), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_zero", 64'(zero), 64'(0));
      chk("rst_ovf", 64'(overflow), 64'(0));

      run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      chk("hold_q", 64'(q), 64'(14));
      chk("hold_r", 64'(r), 64'(2));

      run_div("d5_0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0, 1'b1, 1'b1);
      run_div("d3_10", 32'd3, 32'd10, 32'd0, 32'd3, 1'b1, 1'b0, 1'b1);
      run_div("dmax_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b0);
      run_div("dmax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);

      // Restarts during RUN and during DONE must be ignored.
      d0 = done_cnt;
      @(negedge clk);
      a     = 32'd100;
      b     = 32'd7;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      a     = 32'd9;
      b     = 32'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cyc   = 0;
      while (!done && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("midrun_seen_done", 64'(done), 64'(1));
      start = 1'b1;
      a     = 32'd9;
      b     = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("done_restart_busy", 64'(busy), 64'(0));
      repeat (40) @(posedge clk);
      #1;
      chk("midrun_done_cnt", 64'(done_cnt - d0), 64'(1));
      chk("midrun_q", 64'(q), 64'(14));
      chk("midrun_r", 64'(r), 64'(2));

      // Reset mid-division abandons it without a done pulse.
      d0 = done_cnt;
      @(negedge clk);
      a     = 32'd100;
      b     = 32'd7;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mrst_q", 64'(q), 64'(0));
      chk("mrst_r", 64'(r), 64'(0));
      chk("mrst_busy", 64'(busy), 64'(0));
      chk("mrst_done", 64'(done), 64'(0));
      chk("mrst_zero", 64'(zero), 64'(0));
      chk("mrst_ovf", 64'(overflow), 64'(0));
      repeat (40) @(posedge clk);
      #1;
      chk("mrst_no_done", 64'(done_cnt - d0), 64'(0));

      // Reset and start together start nothing.
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      a     = 32'd9;
      b     = 32'd3;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_start_busy", 64'(busy), 64'(0));
      chk("rst_start_no_done", 64'(done_cnt - d0), 64'(0));

      run_div("d9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0);

      chk("busy_done_overlap", 64'(overlap), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
      $finish;
   end

endmodule
